// File: rtl/cpu_io_pkg.sv
// Shared constants and types for the CPU_IO tile bridge.
// Beat geometry, OPB_O/RES2_I bit map and TX state encoding.
package cpu_io_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int N4 = DEF_WIDTH / 4;
  localparam int N8 = DEF_WIDTH / 8;

  localparam int OPB_VALID  = 0;
  localparam int OPB_FIRST  = 1;
  localparam int OPB_LAST   = 2;
  localparam int OPB_CREDIT = 3;

  localparam int RES2_VALID = 0;
  localparam int RES2_FIRST = 1;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_SEND_A = 2'd1,
    TX_SEND_B = 2'd2
  } tx_state_e;

  function automatic int beats4(input int w);
    return w / 4;
  endfunction

  function automatic int beats8(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/cpu_io_res_fifo.sv
// Result word FIFO: registered storage, combinational head read.
// Push and pop in the same cycle are both honoured, even when full.
module cpu_io_res_fifo
  import cpu_io_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/cpu_io_bridge.sv
// CPU_IO tile BEL: serialises operand pairs onto OPA_O/OPB_O nibbles
// and reassembles result bytes from RES*_I into a small result FIFO.
module cpu_io_bridge
  import cpu_io_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int RES_FIFO_DEPTH = 2
) (
  input  logic                  UserCLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  op_valid,
  output logic                  op_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  input  logic                  err_clr,
  output logic [1:0]            rx_err,
  output logic [3:0]            OPA_O,
  output logic [3:0]            OPB_O,
  input  logic [3:0]            RES0_I,
  input  logic [3:0]            RES1_I,
  input  logic [3:0]            RES2_I
);

  localparam int NB4 = beats4(DATA_WIDTH);
  localparam int NB8 = beats8(DATA_WIDTH);
  localparam int BW  = $clog2(2 * NB4);
  localparam int SW  = (NB8 > 1) ? $clog2(NB8) : 1;
  localparam int FCW = $clog2(RES_FIFO_DEPTH) + 1;

  tx_state_e               state_q, state_d;
  logic [2*DATA_WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [3:0]              opa_q, opa_d;
  logic [2:0]              opb_q, opb_d;
  logic                    rdy_q, rdy_d;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    beat_d  = beat_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      TX_IDLE: begin
        rdy_d = 1'b1;
        opa_d = '0;
        opb_d = '0;
        if (op_valid && rdy_q) begin
          sh_d             = {op_b, op_a} >> 4;
          opa_d            = op_a[3:0];
          opb_d[OPB_VALID] = 1'b1;
          opb_d[OPB_FIRST] = 1'b1;
          beat_d           = '0;
          rdy_d            = 1'b0;
          state_d          = TX_SEND_A;
        end
      end
      default: begin
        if (beat_q == BW'(2 * NB4 - 1)) begin
          state_d = TX_IDLE;
          opa_d   = '0;
          opb_d   = '0;
          rdy_d   = 1'b1;
        end else begin
          beat_d           = beat_q + 1'b1;
          opa_d            = sh_q[3:0];
          sh_d             = sh_q >> 4;
          opb_d            = '0;
          opb_d[OPB_VALID] = 1'b1;
          opb_d[OPB_LAST]  = (beat_d == BW'(2 * NB4 - 1));
          state_d = (beat_d >= BW'(NB4)) ? TX_SEND_B : TX_SEND_A;
        end
      end
    endcase
  end

  // Input stage: RES*_I are sampled once before any use.
  logic [7:0] rbyte_q;
  logic       rval_q;
  logic       rfirst_q;
  logic       unused_res2;

  assign unused_res2 = ^RES2_I[3:2];

  logic [SW-1:0]         cnt_q, cnt_d;
  logic                  open_q, open_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [1:0]            err_q, err_d;
  logic                  credit_q, credit_d;
  logic [SW-1:0]         slot;
  logic                  store;
  logic                  orphan;
  logic                  push;
  logic                  pop;

  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCW-1:0]        fifo_count;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    open_d = open_q;
    store  = 1'b0;
    orphan = 1'b0;
    push   = 1'b0;
    slot   = rfirst_q ? '0 : cnt_q;
    if (rval_q) begin
      if (rfirst_q || open_q) begin
        store = 1'b1;
      end else begin
        orphan = 1'b1;
      end
    end
    if (store) begin
      for (int i = 0; i < NB8; i++) begin
        if (slot == SW'(i)) begin
          word_d[8*i +: 8] = rbyte_q;
        end
      end
      if (slot == SW'(NB8 - 1)) begin
        push   = 1'b1;
        open_d = 1'b0;
        cnt_d  = '0;
      end else begin
        open_d = 1'b1;
        cnt_d  = slot + 1'b1;
      end
    end
  end

  assign pop = !fifo_empty && res_ready;

  // A new error wins over a clear landing in the same cycle.
  always_comb begin
    err_d    = err_q & {2{~err_clr}};
    err_d[0] = err_d[0] | orphan;
    err_d[1] = err_d[1] | (push && fifo_full && !pop);
    credit_d = (fifo_count < FCW'(RES_FIFO_DEPTH));
  end

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      state_q  <= TX_IDLE;
      sh_q     <= '0;
      beat_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rdy_q    <= 1'b0;
      rbyte_q  <= '0;
      rval_q   <= 1'b0;
      rfirst_q <= 1'b0;
      cnt_q    <= '0;
      open_q   <= 1'b0;
      word_q   <= '0;
      err_q    <= '0;
      credit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      beat_q   <= beat_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rdy_q    <= rdy_d;
      rbyte_q  <= {RES1_I, RES0_I};
      rval_q   <= RES2_I[RES2_VALID];
      rfirst_q <= RES2_I[RES2_FIRST];
      cnt_q    <= cnt_d;
      open_q   <= open_d;
      word_q   <= word_d;
      err_q    <= err_d;
      credit_q <= credit_d;
    end
  end

  cpu_io_res_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RES_FIFO_DEPTH)
  ) u_fifo (
    .clk   (UserCLK),
    .rst   (RST),
    .push  (push),
    .wdata (word_d),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign op_ready  = rdy_q;
  assign OPA_O     = opa_q;
  assign OPB_O     = {credit_q, opb_q};
  assign res_data  = fifo_rdata;
  assign res_valid = !fifo_empty;
  assign rx_err    = err_q;

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed bench for cpu_io_bridge: TX serialisation, RX assembly,
// resync, orphan/overflow errors and mid-frame reset.
module tb_cpu_io_bridge;

  logic        UserCLK;
  logic        RST;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        err_clr;
  logic [1:0]  rx_err;
  logic [3:0]  OPA_O;
  logic [3:0]  OPB_O;
  logic [3:0]  RES0_I;
  logic [3:0]  RES1_I;
  logic [3:0]  RES2_I;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] exp_nib [16] = '{
    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
    4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD
  };

  cpu_io_bridge #(
    .DATA_WIDTH     (32),
    .RES_FIFO_DEPTH (2)
  ) dut (
    .UserCLK   (UserCLK),
    .RST       (RST),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .err_clr   (err_clr),
    .rx_err    (rx_err),
    .OPA_O     (OPA_O),
    .OPB_O     (OPB_O),
    .RES0_I    (RES0_I),
    .RES1_I    (RES1_I),
    .RES2_I    (RES2_I)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  task automatic step();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] b, input logic first);
    RES0_I = b[3:0];
    RES1_I = b[7:4];
    RES2_I = {2'b00, first, 1'b1};
    step();
  endtask

  task automatic rx_idle();
    RES0_I = '0;
    RES1_I = '0;
    RES2_I = '0;
  endtask

  task automatic frame(input logic [31:0] w);
    beat(w[7:0], 1'b1);
    beat(w[15:8], 1'b0);
    beat(w[23:16], 1'b0);
    beat(w[31:24], 1'b0);
  endtask

  initial begin
    RST       = 1'b1;
    op_a      = '0;
    op_b      = '0;
    op_valid  = 1'b0;
    res_ready = 1'b0;
    err_clr   = 1'b0;
    rx_idle();
    step();
    step();
    check("rst_opa", 32'(OPA_O), 32'h0);
    check("rst_opb", 32'(OPB_O), 32'h0);
    check("rst_ready", 32'(op_ready), 32'h0);
    check("rst_rvalid", 32'(res_valid), 32'h0);
    check("rst_rdata", res_data, 32'h0);
    check("rst_err", 32'(rx_err), 32'h0);
    RST = 1'b0;
    step();
    check("ready_up", 32'(op_ready), 32'h1);
    check("credit_up", 32'(OPB_O), 32'h8);

    // TX frame
    op_a     = 32'h87654321;
    op_b     = 32'hDEADBEEF;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tx_nib%0d", i), 32'(OPA_O), 32'(exp_nib[i]));
      check($sformatf("tx_opb%0d", i), 32'(OPB_O),
            {28'h0, 1'b1, (i == 15), (i == 0), 1'b1});
      check($sformatf("tx_rdy%0d", i), 32'(op_ready), 32'h0);
      step();
    end
    check("tx_end_opb", 32'(OPB_O), 32'h8);
    check("tx_end_rdy", 32'(op_ready), 32'h1);

    // RX single word
    frame(32'h12345678);
    rx_idle();
    check("rx1_lat", 32'(res_valid), 32'h0);
    step();
    check("rx1_valid", 32'(res_valid), 32'h1);
    check("rx1_data", res_data, 32'h12345678);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("rx1_popped", 32'(res_valid), 32'h0);

    // Resync on a new FIRST
    beat(8'h11, 1'b1);
    beat(8'h22, 1'b0);
    frame(32'hDDCCBBAA);
    rx_idle();
    step();
    check("rs_valid", 32'(res_valid), 32'h1);
    check("rs_data", res_data, 32'hDDCCBBAA);
    check("rs_err", 32'(rx_err), 32'h0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("rs_one", 32'(res_valid), 32'h0);

    // Orphan beat
    beat(8'h55, 1'b0);
    rx_idle();
    step();
    check("orph_err", 32'(rx_err), 32'h1);
    check("orph_nopush", 32'(res_valid), 32'h0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("orph_clr", 32'(rx_err), 32'h0);

    // Overflow
    frame(32'h04030201);
    frame(32'h14131211);
    frame(32'h24232221);
    rx_idle();
    step();
    check("ovf_err", 32'(rx_err), 32'h2);
    check("ovf_credit", 32'(OPB_O[3]), 32'h0);
    check("ovf_head0", res_data, 32'h04030201);
    res_ready = 1'b1;
    step();
    check("ovf_head1", res_data, 32'h14131211);
    check("ovf_valid1", 32'(res_valid), 32'h1);
    step();
    res_ready = 1'b0;
    check("ovf_empty", 32'(res_valid), 32'h0);
    check("ovf_credit_back", 32'(OPB_O[3]), 32'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovf_clr", 32'(rx_err), 32'h0);

    // Reset mid SEND_A
    op_a     = 32'h87654321;
    op_b     = 32'h0;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    step();
    step();
    step();
    check("mid_beat3", 32'(OPA_O), 32'h4);
    RST = 1'b1;
    #1;
    check("mid_opa", 32'(OPA_O), 32'h0);
    check("mid_opb", 32'(OPB_O), 32'h0);
    check("mid_rdy", 32'(op_ready), 32'h0);
    step();
    RST = 1'b0;
    step();
    check("post_rdy", 32'(op_ready), 32'h1);
    check("post_opb", 32'(OPB_O), 32'h8);
    op_a     = 32'h0000000A;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    check("post_nib0", 32'(OPA_O), 32'hA);
    check("post_opb0", 32'(OPB_O), 32'hB);
    check("post_busy", 32'(op_ready), 32'h0);
    repeat (16) step();
    check("post_end_opb", 32'(OPB_O), 32'h8);
    check("post_end_rdy", 32'(op_ready), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_io_bridge.md
Name: cpu_io_bridge

Overview:
- Tile-side BEL of the CPU_IO tile, located between the CPU operand/result ports and the CPU_IO switch matrix.
- Drives the OPA_O/OPB_O nibbles that the switch matrix routes westward. Consumes the RES0_I/RES1_I/RES2_I nibbles that the switch matrix delivers from eastward E6 wires.
- Serialises 32-bit operand pairs into 4-bit beats. Deserialises 8-bit result beats into 32-bit words, buffered in a small FIFO.

Parameters:
- DATA_WIDTH, 32, operand/result word width; must be a multiple of 8.
- RES_FIFO_DEPTH, 2, result FIFO entries; must be a power of 2, ≥2.

Ports:
- UserCLK  in  1  fabric user clock
- RST  in  1  reset, asynchronous, active-high
- op_a  in  DATA_WIDTH  operand A from CPU
- op_b  in  DATA_WIDTH  operand B from CPU
- op_valid  in  1  operand pair valid
- op_ready  out  1  bridge accepts operand pair
- res_data  out  DATA_WIDTH  result word, FIFO head
- res_valid  out  1  FIFO non-empty
- res_ready  in  1  CPU pops head
- err_clr  in  1  clears sticky errors
- rx_err  out  2  sticky: [0] orphan beat, [1] FIFO overflow
- OPA_O  out  4  operand data nibble to switch matrix
- OPB_O  out  4  [0] beat valid, [1] frame first, [2] frame last, [3] result credit
- RES0_I  in  4  result byte, low nibble
- RES1_I  in  4  result byte, high nibble
- RES2_I  in  4  [0] beat valid, [1] frame first, [3:2] ignored

Behaviour:
- Clock and reset: single clock UserCLK; RST asynchronous, active-high. All flops reset.
- Reset values: OPA_O=0, OPB_O=0, op_ready=0, res_valid=0, res_data=0, rx_err=0, FIFO empty, TX in IDLE, RX beat counter 0.
- op_ready rises on the first edge after RST deasserts.
- RST mid-frame aborts the frame with no flush beat. The fabric must treat a frame lacking a "last" beat as discarded.

TX FSM (states IDLE, SEND_A, SEND_B; all outputs registered):
- IDLE: op_ready=1. op_valid&&op_ready at edge k captures A and B, clears op_ready, enters SEND_A.
- SEND_A: one beat per cycle, N4=DATA_WIDTH/4 beats, LSB nibble first. OPA_O=nibble, OPB_O[0]=1; OPB_O[1]=1 on beat 0 only.
- SEND_B: N4 beats of B in the same format; OPB_O[2]=1 on its final beat.
- Return to IDLE after the final beat. OPB_O[2:0] go 0 the cycle after.
- Frame length is 2*N4 cycles. Minimum spacing between frame starts is 2*N4+1 cycles.
- No fabric backpressure on operands.

RX path:
- RES*_I are registered once (input stage) before use.
- Beat byte = {RES1_I,RES0_I}; bytes arrive LSB byte first; N8=DATA_WIDTH/8 beats per word.
- valid&&first: beat counter forced to 0 and the byte stored at slot 0. Any partial word is discarded silently (resync).
- valid&&!first with counter==0 and no frame open: byte dropped, rx_err[0] set.
- After beat N8-1 is stored, the assembled word is pushed into the FIFO on the next edge and the frame closes.
- Latency: last beat on the pins at edge k → input register at k → FIFO push at k+1 → res_valid=1 after k+1.
- Push while FIFO full with no simultaneous pop: word dropped, rx_err[1] set. A push and pop in the same cycle while full are both honoured.
- Pop occurs on res_valid&&res_ready; res_data shows the new head on the next cycle.
- OPB_O[3] (credit) is a registered (count < RES_FIFO_DEPTH) flag, advisory for the fabric.
- rx_err bits are sticky. err_clr clears them; a set and a clear in the same cycle resolve to set.

Decomposition:
- Package cpu_io_pkg holds:
  - beat counts N4/N8,
  - OPB_O bit-index constants (VALID=0, FIRST=1, LAST=2, CREDIT=3),
  - RES2_I bit indices,
  - the TX state enum.
- One sub-module, cpu_io_res_fifo: synchronous FIFO with full/empty/count outputs and simultaneous push/pop support.

Test Plan:
- Reset, then op_a=0x87654321, op_b=0xDEADBEEF → 16 beats: OPA_O = 1,2,3,4,5,6,7,8,F,E,E,B,D,A,E,D. FIRST on beat 0, LAST on beat 15, op_ready=0 throughout, op_ready=1 one cycle after.
- RX: 4 beats of bytes 0x78,0x56,0x34,0x12 with FIRST on beat 0 → res_data=0x12345678, res_valid=1 two edges after the last beat.
- RX: 2 beats, then a new FIRST frame 0xAA,0xBB,0xCC,0xDD → exactly one word 0xDDCCBBAA; rx_err=0.
- Orphan beat (valid, !first, idle) → rx_err=2'b01; err_clr → 2'b00.
- res_ready=0 with 3 frames → FIFO holds the first 2, rx_err[1]=1, credit=0. Pop twice → first two words in order, credit returns to 1.
- Assert RST during SEND_A beat 3 → OPA_O/OPB_O zero immediately. After release, op_ready=1 and a new frame starts from beat 0.
